imem_boot_loader: RTL

//   Upstream boot stage for the multicycle CPU. Receives a program image as a byte stream
//   and writes it word-by-word into the CPU instruction memory write port. Holds the CPU in

---
 rtl/imem_boot_loader_pkg.sv | 28 ++
 rtl/imem_boot_loader_if.sv | 33 +++
 rtl/imem_boot_loader_word_assembler.sv | 36 +++
 rtl/imem_boot_loader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: field widths,
// default frame marker and FSM state encoding.
package imem_boot_loader_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned BCNT_W = 2;

   localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHECK  = 3'd4,
      ST_RUN    = 3'd5,
      ST_ERR    = 3'd6
   } state_e;

   // Every non-terminal state takes one byte per cycle.
   function automatic logic accepts_bytes(input state_e s);
      return (s == ST_IDLE) || (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
             (s == ST_DATA) || (s == ST_CHECK);
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if
   import imem_boot_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
);
   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [WORD_W-1:0] imem_wdata;

   // The loader consumes bytes and drives the memory write port.
   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   // The host supplies bytes and observes the write port.
   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs big-endian bytes into 32-bit words and keeps a running XOR of every byte.
module boot_word_assembler
   import imem_boot_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_byte_en,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [WORD_W-1:0] o_word_c,
   output logic              o_word_ready_c,
   output logic [BYTE_W-1:0] o_chk
);

   logic [WORD_W-BYTE_W-1:0] r_shift;
   logic [BCNT_W-1:0]        r_cnt;
   logic [BYTE_W-1:0]        r_chk;

   // Only the three earlier bytes are stored; the fourth is taken straight from the input.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_chk   <= '0;
      end else if (i_byte_en) begin
         r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
         r_cnt   <= r_cnt + BCNT_W'(1);
         r_chk   <= r_chk ^ i_byte;
      end
   end

   assign o_word_c       = {r_shift, i_byte};
   assign o_word_ready_c = i_byte_en && (r_cnt == BCNT_W'(3));
   assign o_chk          = r_chk;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a framed byte stream into instruction memory and holds the
// CPU in reset until the image checksum verifies.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 8,
   parameter int unsigned       DEPTH     = 256,
   parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
)(
   input  logic               clk,
   input  logic               reset,
   imem_boot_loader_if.slave  bus,
   output logic               cpu_reset,
   output logic               done,
   output logic               error,
   output logic [LEN_W-1:0]   words_loaded
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [BYTE_W-1:0]  r_len_hi;
   logic [BYTE_W-1:0]  w_len_hi_nxt;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   w_len_nxt;
   logic [LEN_W-1:0]   r_word_idx;
   logic [LEN_W-1:0]   w_word_idx_nxt;
   logic [LEN_W-1:0]   w_len_rx;

   logic               w_xfer;
   logic               w_clear;
   logic               w_byte_en;
   logic [WORD_W-1:0]  w_word;
   logic               w_word_ready;
   logic [BYTE_W-1:0]  w_chk;

   logic               r_rx_ready;
   logic               r_imem_we;
   logic [ADDR_W-1:0]  r_imem_addr;
   logic [WORD_W-1:0]  r_imem_wdata;
   logic               r_cpu_reset;
   logic               r_done;
   logic               r_error;
   logic [LEN_W-1:0]   r_words_loaded;

   assign w_xfer    = bus.rx_valid && r_rx_ready;
   assign w_len_rx  = {r_len_hi, bus.rx_data};
   assign w_byte_en = w_xfer && (r_state == ST_DATA);
   // A new frame starts from a clean assembler and checksum.
   assign w_clear   = w_xfer && (r_state == ST_IDLE) && (bus.rx_data == SYNC_BYTE);

   boot_word_assembler u_asm (
      .clk            (clk),
      .reset          (reset),
      .i_clear        (w_clear),
      .i_byte_en      (w_byte_en),
      .i_byte         (bus.rx_data),
      .o_word_c       (w_word),
      .o_word_ready_c (w_word_ready),
      .o_chk          (w_chk)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_len_hi   <= '0;
         r_len      <= '0;
         r_word_idx <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_len_hi   <= w_len_hi_nxt;
         r_len      <= w_len_nxt;
         r_word_idx <= w_word_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_len_hi_nxt   = r_len_hi;
      w_len_nxt      = r_len;
      w_word_idx_nxt = r_word_idx;
      case (r_state)
         ST_IDLE: begin
            if (w_clear) begin
               w_state_nxt    = ST_LEN_HI;
               w_word_idx_nxt = '0;
            end
         end
         ST_LEN_HI: begin
            if (w_xfer) begin
               w_len_hi_nxt = bus.rx_data;
               w_state_nxt  = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (w_xfer) begin
               w_len_nxt = w_len_rx;
               if (32'(w_len_rx) > DEPTH)  w_state_nxt = ST_ERR;
               else if (w_len_rx == '0)    w_state_nxt = ST_CHECK;
               else                        w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_word_ready) begin
               w_word_idx_nxt = r_word_idx + LEN_W'(1);
               if (r_word_idx == r_len - LEN_W'(1)) w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (w_xfer) w_state_nxt = (bus.rx_data == w_chk) ? ST_RUN : ST_ERR;
         end
         ST_RUN:  w_state_nxt = ST_RUN;
         ST_ERR:  w_state_nxt = ST_ERR;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Status and memory-port registers follow the next state so they change with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_ready     <= 1'b0;
         r_imem_we      <= 1'b0;
         r_imem_addr    <= '0;
         r_imem_wdata   <= '0;
         r_cpu_reset    <= 1'b1;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
         r_words_loaded <= '0;
      end else begin
         r_rx_ready  <= accepts_bytes(w_state_nxt);
         r_imem_we   <= w_word_ready;
         r_cpu_reset <= (w_state_nxt != ST_RUN);
         r_done      <= (w_state_nxt == ST_RUN);
         r_error     <= (w_state_nxt == ST_ERR);
         if (w_word_ready) begin
            r_imem_addr    <= ADDR_W'(r_word_idx);
            r_imem_wdata   <= w_word;
            r_words_loaded <= r_word_idx + LEN_W'(1);
         end
      end
   end

   assign bus.rx_ready   = r_rx_ready;
   assign bus.imem_we    = r_imem_we;
   assign bus.imem_addr  = r_imem_addr;
   assign bus.imem_wdata = r_imem_wdata;
   assign cpu_reset      = r_cpu_reset;
   assign done           = r_done;
   assign error          = r_error;
   assign words_loaded   = r_words_loaded;

endmodule
